// File: rtl/sram_1rw1r_ctrl.sv
// Initiator-side controller for a 32x256 1RW+1R SRAM macro: valid/ready request
// channels in, active-low macro controls out, credit-limited 2-entry read-response FIFOs.

module sram_1rw1r_fifo_chk (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_push,
  input logic i_pop,
  input logic i_full
);
  // Credit accounting guarantees a full FIFO is never pushed without a pop.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && i_full));
endmodule

module sram_1rw1r_rsp_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_rd_fire,
  input  logic [DATA_W-1:0] i_dout,
  input  logic              i_rsp_ready,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rd_ready
);
  logic              r_inflight;
  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_occ;

  assign w_push      = r_inflight;
  assign o_rsp_valid = (r_count != 2'd0);
  assign o_rsp_rdata = r_mem[r_rptr];
  assign w_pop       = o_rsp_valid & i_rsp_ready;
  assign w_occ       = {1'b0, r_inflight} + r_count;
  // A pop in this cycle frees a slot for the read being accepted alongside it.
  assign o_rd_ready  = (w_occ < 2'd2) | w_pop;

  // Read-in-flight flag, FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= 1'b0;
      r_mem[0]   <= {DATA_W{1'b0}};
      r_mem[1]   <= {DATA_W{1'b0}};
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= i_rd_fire;
      if (w_push) begin
        r_mem[r_wptr] <= i_dout;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  sram_1rw1r_fifo_chk u_chk (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_full  (r_count == 2'd2)
  );
endmodule

module sram_1rw1r_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_req_valid_i,
  output logic              a_req_ready_o,
  input  logic              a_req_we_i,
  input  logic [3:0]        a_req_wmask_i,
  input  logic [ADDR_W-1:0] a_req_addr_i,
  input  logic [DATA_W-1:0] a_req_wdata_i,
  output logic              a_rsp_valid_o,
  input  logic              a_rsp_ready_i,
  output logic [DATA_W-1:0] a_rsp_rdata_o,
  input  logic              b_req_valid_i,
  output logic              b_req_ready_o,
  input  logic [ADDR_W-1:0] b_req_addr_i,
  output logic              b_rsp_valid_o,
  input  logic              b_rsp_ready_i,
  output logic [DATA_W-1:0] b_rsp_rdata_o,
  output logic              sram_csb0_o,
  output logic              sram_web0_o,
  output logic [3:0]        sram_wmask0_o,
  output logic [ADDR_W-1:0] sram_addr0_o,
  output logic [DATA_W-1:0] sram_din0_o,
  input  logic [DATA_W-1:0] sram_dout0_i,
  output logic              sram_csb1_o,
  output logic [ADDR_W-1:0] sram_addr1_o,
  input  logic [DATA_W-1:0] sram_dout1_i
);
  logic w_a_rd_ready;
  logic w_b_rd_ready;
  logic w_collision;
  logic w_a_fire;
  logic w_b_fire;

  // B reading the word A writes this cycle would see undefined data; hold B off one cycle.
  assign w_collision   = a_req_valid_i & a_req_we_i & b_req_valid_i &
                         (a_req_addr_i == b_req_addr_i);
  assign a_req_ready_o = a_req_we_i | w_a_rd_ready;
  assign b_req_ready_o = w_b_rd_ready & ~w_collision;

  // Gating with rst_ni keeps both chip selects inactive while reset is held.
  assign w_a_fire = a_req_valid_i & a_req_ready_o & rst_ni;
  assign w_b_fire = b_req_valid_i & b_req_ready_o & rst_ni;

  assign sram_csb0_o   = ~w_a_fire;
  assign sram_web0_o   = ~(w_a_fire & a_req_we_i);
  assign sram_wmask0_o = a_req_wmask_i;
  assign sram_addr0_o  = a_req_addr_i;
  assign sram_din0_o   = a_req_wdata_i;
  assign sram_csb1_o   = ~w_b_fire;
  assign sram_addr1_o  = b_req_addr_i;

  sram_1rw1r_rsp_port #(.DATA_W(DATA_W)) u_port_a (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_rd_fire   (w_a_fire & ~a_req_we_i),
    .i_dout      (sram_dout0_i),
    .i_rsp_ready (a_rsp_ready_i),
    .o_rsp_valid (a_rsp_valid_o),
    .o_rsp_rdata (a_rsp_rdata_o),
    .o_rd_ready  (w_a_rd_ready)
  );

  sram_1rw1r_rsp_port #(.DATA_W(DATA_W)) u_port_b (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_rd_fire   (w_b_fire),
    .i_dout      (sram_dout1_i),
    .i_rsp_ready (b_rsp_ready_i),
    .o_rsp_valid (b_rsp_valid_o),
    .o_rsp_rdata (b_rsp_rdata_o),
    .o_rd_ready  (w_b_rd_ready)
  );
endmodule

// File: doc/sram_1rw1r_ctrl.md
# sram_1rw1r_ctrl

Initiator-side controller for the 32x256 1RW+1R SRAM macro. It turns two valid/ready request channels into the macro's active-low chip-select and write-enable port controls: channel A is read/write on port 0, channel B is read-only on port 1. Read data is returned over valid/ready response channels. Each port has a credit-limited 2-entry response FIFO, so the macro's fixed read latency never loses data under backpressure. The block sits between the core-side memory arbiter and the macro instance.

## Interface
- ADDR_W, 8, word-address width; must match macro depth 256
- DATA_W, 32, data width; must match macro word
- Reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; also drives macro clk0/clk1
- rst_ni  in  1  asynchronous active-low reset
- a_req_valid_i  in  1  channel A request valid
- a_req_ready_o  out  1  channel A request ready
- a_req_we_i  in  1  1 = write, 0 = read
- a_req_wmask_i  in  4  byte write mask; ignored on reads
- a_req_addr_i  in  ADDR_W  word address
- a_req_wdata_i  in  DATA_W  write data
- a_rsp_valid_o / a_rsp_ready_i  out/in  1  channel A read response handshake
- a_rsp_rdata_o  out  DATA_W  channel A read data
- b_req_valid_i / b_req_ready_o  in/out  1  channel B read request handshake
- b_req_addr_i  in  ADDR_W  channel B word address
- b_rsp_valid_o / b_rsp_ready_i  out/in  1  channel B read response handshake
- b_rsp_rdata_o  out  DATA_W  channel B read data
- sram_csb0_o, sram_web0_o  out  1  macro port 0 controls, active-low
- sram_wmask0_o  out  4  macro port 0 write mask
- sram_addr0_o  out  ADDR_W  macro port 0 address
- sram_din0_o  out  DATA_W  macro port 0 write data
- sram_dout0_i  in  DATA_W  macro port 0 read data
- sram_csb1_o  out  1  macro port 1 control, active-low
- sram_addr1_o  out  ADDR_W  macro port 1 address
- sram_dout1_i  in  DATA_W  macro port 1 read data

## Operation
- A request is accepted (fire) when valid and ready are both high on a rising edge. Macro controls are combinational from the fire:
  - csb0 = ~a_fire
  - web0 = ~(a_fire & we)
  - addr, din and wmask pass straight through
  - all macro outputs are don't-care while the matching csb is high
- Writes produce no response and do not consume a credit.
- Each port has the same structure:
  - inflight flag: set on a read fire, cleared the next cycle
  - 2-entry FIFO: pushes sram_dout on the cycle after the read fire
  - rsp_valid = FIFO not empty; rsp_rdata = FIFO head; pop on rsp fire
- Credit: occ = inflight + FIFO count. Read ready = (occ < 2) | rsp_fire.
- Channel A writes are always ready.
- Collision: a B read to the same address as an A write in the same cycle gives undefined macro data. In that case b_req_ready_o is forced low for that cycle; the B request is retried next cycle.
- Ports A and B are otherwise fully independent, including a same-address A read with a B read.
- Ordering: responses on a port return in request order.

## Timing
- Reset values:
  - sram_csb0_o, sram_csb1_o, sram_web0_o = 1
  - rsp_valid = 0, FIFOs empty, inflight = 0
  - a_req_ready_o = 1, b_req_ready_o = 1 when b_req_valid_i = 0
- Read latency: fire at cycle N, macro dout sampled at cycle N+1 edge, rsp_valid high from cycle N+2.
- Sustained throughput with rsp_ready held high is 1 read per cycle per port.
- Backpressure: after two un-popped reads, req_ready drops. It rises in the same cycle as a response pop.
- FIFO pointers are 1-bit and wrap at 2. Simultaneous push and pop on a full FIFO is legal. With correct credit, push on full without pop cannot occur; this is an assertion.
- Reset asserted mid-operation: in-flight reads and buffered data are discarded and all outputs return to reset values asynchronously. Any macro access already started is abandoned.

## Test plan
- Write then read: A write addr 0x10, data 0xDEADBEEF, wmask 0xF; A read 0x10 at cycle N -> a_rsp_valid at N+2 with data 0xDEADBEEF; no response for the write.
- Byte mask: write 0x11223344 with mask 0x3 over 0xFFFFFFFF at addr 0x20, read back -> 0xFFFF3344.
- Backpressure: rsp_ready = 0, issue 3 back-to-back B reads of 0x01, 0x02, 0x03 -> only 2 accepted and b_req_ready_o low. Release rsp_ready -> data returns in order, then the third read is accepted.
- Collision: same cycle, A write 0x40 and B read 0x40 -> b_req_ready_o = 0 that cycle. B fires the next cycle and returns the new data.
- Streaming: 256 consecutive A reads with rsp_ready = 1 -> one accept per cycle, responses contiguous, data equal to the model.
- Reset mid-stream: assert rst_ni low with 2 responses buffered -> rsp_valid = 0 and csb = 1 immediately; after release, ready = 1 and no stale response appears.
